secure_serdes_decryptor_core: RTL and testbench

Receive-side counterpart of the secure SerDes encryptor core. Deserializes an 8-bit cipher frame (MSB first) together with the matching serial B-operand stream, and recovers the plaintext byte A = C ^ B ^ key[7:0]. Presents the byte on a parallel valid/ready output register, with a sticky overrun flag and a frame counter. Sits between the serial link pins and downstream parallel logic in the tt_um top level.

---
 rtl/secure_serdes_decryptor_core.sv | 148 ++++++++++++++
 tb/tb_secure_serdes_decryptor_core.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secure_serdes_decryptor_core.sv
// ---------------------------------------------------------------------------
// secure_serdes_decryptor_core
//
// Receive side of the secure SerDes link. After a start strobe, eight cipher
// bits and eight B-operand bits are shifted in MSB first. The plaintext byte
// A = C ^ B ^ key[7:0] is then offered on a one-deep valid/ready output
// register. If that register is still occupied when a new byte is ready, the
// new byte is dropped and the sticky overrun flag is raised.
//
// Parameters:
//   FILTER_EN   1 = cipher_bit goes through a 3-tap majority vote before
//               capture, 0 = raw capture
//   CNT_W       width of frame_cnt
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous, active-high reset
//   start        frame start strobe, only looked at while idle
//   cipher_bit   serial cipher stream, MSB first
//   b_bit        serial B-operand stream, bit-aligned with cipher_bit
//   key          key; only key[7:0] takes part in the decryption
//   plain_ready  downstream accepts plain_byte
//   clr_err      synchronous clear of overrun
//   plain_byte   recovered plaintext
//   plain_valid  plain_byte holds an unconsumed byte
//   busy         a frame is in progress
//   overrun      sticky: a decrypted byte was dropped
//   frame_cnt    bytes delivered to plain_byte, wraps silently
// ---------------------------------------------------------------------------
module secure_serdes_decryptor_core #(
   parameter bit FILTER_EN = 1'b0,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cipher_bit,
   input  logic             b_bit,
   input  logic [127:0]     key,
   input  logic             plain_ready,
   input  logic             clr_err,
   output logic [7:0]       plain_byte,
   output logic             plain_valid,
   output logic             busy,
   output logic             overrun,
   output logic [CNT_W-1:0] frame_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_DECRYPT = 2'd2
   } state_t;

   state_t      state_r;
   logic [7:0]  c_sh_r;
   logic [7:0]  b_sh_r;
   logic [2:0]  bit_cnt_r;
   logic [1:0]  filt_r;
   logic        vote_s;
   logic        cap_bit_s;
   logic [7:0]  res_s;
   logic        load_ok_s;
   logic        unused_key_s;

   // True when at least two of the three inputs are 1.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // The upper key bits are carried on the port for the shared key bus only.
   assign unused_key_s = ^key[127:8];

   assign vote_s    = maj3(filt_r[1], filt_r[0], cipher_bit);
   assign res_s     = c_sh_r ^ b_sh_r ^ key[7:0];
   // The output register can take a new byte if it is empty or being drained
   // on this very edge.
   assign load_ok_s = (~plain_valid) | plain_ready;
   assign busy      = (state_r != ST_IDLE);

   // Select the bit that enters the cipher shift register.
   always_comb begin
      cap_bit_s = cipher_bit;
      if (FILTER_EN) begin
         cap_bit_s = vote_s;
      end else begin
         cap_bit_s = cipher_bit;
      end
   end

   // Frame FSM, deserializers, output register, overrun flag and frame counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         c_sh_r      <= 8'h00;
         b_sh_r      <= 8'h00;
         bit_cnt_r   <= 3'd0;
         filt_r      <= 2'b00;
         plain_byte  <= 8'h00;
         plain_valid <= 1'b0;
         overrun     <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         // Clear first so that a drop later in this block takes priority.
         if (clr_err) begin
            overrun <= 1'b0;
         end
         // Consume; a load further down overrides this on the same edge.
         if (plain_valid && plain_ready) begin
            plain_valid <= 1'b0;
         end
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  c_sh_r    <= 8'h00;
                  b_sh_r    <= 8'h00;
                  bit_cnt_r <= 3'd0;
                  filt_r    <= 2'b00;
                  state_r   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               c_sh_r    <= {c_sh_r[6:0], cap_bit_s};
               b_sh_r    <= {b_sh_r[6:0], b_bit};
               filt_r    <= {filt_r[0], cipher_bit};
               bit_cnt_r <= bit_cnt_r + 3'd1;
               if (bit_cnt_r == 3'd7) begin
                  state_r <= ST_DECRYPT;
               end
            end
            ST_DECRYPT: begin
               if (load_ok_s) begin
                  plain_byte  <= res_s;
                  plain_valid <= 1'b1;
                  frame_cnt   <= frame_cnt + CNT_W'(1);
               end else begin
                  overrun <= 1'b1;
               end
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_secure_serdes_decryptor_core.sv
// ---------------------------------------------------------------------------
// tb_secure_serdes_decryptor_core
//
// Drives one stimulus stream into two instances (raw capture and majority
// filtered capture). A frame-level reference model predicts each delivered
// byte, the drop/overrun behaviour and the frame count; predictions go into a
// queue that a negedge monitor drains whenever the DUT presents a new byte.
// ---------------------------------------------------------------------------
module tb_secure_serdes_decryptor_core;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         cipher_bit = 1'b0;
   logic         b_bit = 1'b0;
   logic [127:0] key = 128'h0;
   logic         plain_ready = 1'b0;
   logic         clr_err = 1'b0;

   logic [7:0]   p0_byte, p1_byte;
   logic         p0_valid, p1_valid;
   logic         busy0, busy1;
   logic         ovr0, ovr1;
   logic [7:0]   cnt0, cnt1;

   secure_serdes_decryptor_core #(.FILTER_EN(1'b0), .CNT_W(8)) dut_raw (
      .clk(clk), .rst(rst), .start(start), .cipher_bit(cipher_bit),
      .b_bit(b_bit), .key(key), .plain_ready(plain_ready), .clr_err(clr_err),
      .plain_byte(p0_byte), .plain_valid(p0_valid), .busy(busy0),
      .overrun(ovr0), .frame_cnt(cnt0)
   );

   secure_serdes_decryptor_core #(.FILTER_EN(1'b1), .CNT_W(8)) dut_flt (
      .clk(clk), .rst(rst), .start(start), .cipher_bit(cipher_bit),
      .b_bit(b_bit), .key(key), .plain_ready(plain_ready), .clr_err(clr_err),
      .plain_byte(p1_byte), .plain_valid(p1_valid), .busy(busy1),
      .overrun(ovr1), .frame_cnt(cnt1)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] cnt;
   } exp_t;

   // reference model state
   bit         m_active = 1'b0;
   int         m_age = 0;
   bit         m_cs [8];
   bit         m_bs [8];
   bit         m_full = 1'b0;
   bit         m_ovr = 1'b0;
   logic [7:0] m_cnt = 8'd0;
   exp_t       exp_q [$];

   int rdy_mode  = 1;   // 0: ready low, 1: ready high, 2: random
   int rdy_force = -1;  // >=0 overrides rdy_mode
   int n_checks  = 0;
   int n_err     = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_age    = 0;
      m_full   = 1'b0;
      m_ovr    = 1'b0;
      m_cnt    = 8'd0;
      exp_q.delete();
   endtask

   // Frame-level model: a frame is the 8 sample cycles after a start seen while
   // idle, followed by one decision cycle.
   task automatic model_edge();
      bit   load;
      bit   drop;
      int   craw, cflt, bv, ones;
      exp_t e;
      load = 1'b0;
      drop = 1'b0;
      if (rst) begin
         model_reset();
         return;
      end
      if (m_active) begin
         m_age++;
         if (m_age <= 8) begin
            m_cs[m_age-1] = cipher_bit;
            m_bs[m_age-1] = b_bit;
         end else begin
            craw = 0; cflt = 0; bv = 0;
            for (int i = 0; i < 8; i++) begin
               ones = 0;
               for (int k = i - 2; k <= i; k++) begin
                  if (k >= 0) ones += int'(m_cs[k]);
               end
               craw = craw * 2 + int'(m_cs[i]);
               cflt = cflt * 2 + ((ones >= 2) ? 1 : 0);
               bv   = bv * 2 + int'(m_bs[i]);
            end
            e.b0  = 8'(craw) ^ 8'(bv) ^ key[7:0];
            e.b1  = 8'(cflt) ^ 8'(bv) ^ key[7:0];
            e.cnt = m_cnt + 8'd1;
            if (!m_full || plain_ready) begin
               load = 1'b1;
               exp_q.push_back(e);
            end else begin
               drop = 1'b1;
            end
            m_active = 1'b0;
         end
      end else if (start) begin
         m_active = 1'b1;
         m_age    = 0;
      end
      if (load) begin
         m_cnt  = m_cnt + 8'd1;
         m_full = 1'b1;
      end else if (m_full && plain_ready) begin
         m_full = 1'b0;
      end
      if (drop) m_ovr = 1'b1;
      else if (clr_err) m_ovr = 1'b0;
   endtask

   // One clock: apply ready, take the edge, advance the model, settle.
   task automatic tick();
      if (rdy_force >= 0) plain_ready = rdy_force[0];
      else if (rdy_mode == 2) plain_ready = 1'($urandom_range(0, 1));
      else plain_ready = (rdy_mode == 1);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] b, input int glitch,
                             input int dec_rdy, input bit dec_clr, input bit noisy,
                             output bit v_before);
      start = 1'b1; cipher_bit = 1'($urandom); b_bit = 1'($urandom);
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cipher_bit = c[7-i] ^ (i == glitch);
         b_bit      = b[7-i];
         if (noisy) start = 1'($urandom_range(0, 1));
         tick();
      end
      start      = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      cipher_bit = 1'($urandom);
      b_bit      = 1'($urandom);
      rdy_force  = dec_rdy;
      clr_err    = dec_clr;
      v_before   = p0_valid;
      tick();
      rdy_force = -1;
      clr_err   = 1'b0;
      start     = 1'b0;
   endtask

   // Monitor: per-cycle status against the model, byte/count on presentation.
   logic       prev_v = 1'b0;
   logic       prev_r = 1'b0;
   logic [7:0] last_b0 = 8'h00;
   logic [7:0] last_b1 = 8'h00;

   always @(negedge clk) begin : monitor
      exp_t e;
      check("valid_raw", p0_valid, m_full);
      check("valid_flt", p1_valid, m_full);
      check("busy_raw", busy0, m_active);
      check("busy_flt", busy1, m_active);
      check("overrun_raw", ovr0, m_ovr);
      check("overrun_flt", ovr1, m_ovr);
      if (p0_valid && !(prev_v && !prev_r)) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_byte: got %0h expected none at %0t", p0_byte, $time);
         end else begin
            e = exp_q.pop_front();
            check("byte_raw", p0_byte, e.b0);
            check("byte_flt", p1_byte, e.b1);
            check("cnt_raw", cnt0, e.cnt);
            check("cnt_flt", cnt1, e.cnt);
            last_b0 <= e.b0;
            last_b1 <= e.b1;
         end
      end else if (p0_valid) begin
         check("hold_raw", p0_byte, last_b0);
         check("hold_flt", p1_byte, last_b1);
      end
      prev_v <= p0_valid;
      prev_r <= plain_ready;
   end

   initial begin : stimulus
      bit         vb;
      logic [7:0] cnt_before;
      key = {$urandom, $urandom, $urandom, $urandom};
      key[7:0] = 8'h34;
      rst = 1'b1;
      model_reset();
      repeat (2) tick();
      check("rst_byte", p0_byte, 8'h00);
      check("rst_valid", p0_valid, 1'b0);
      check("rst_busy", busy0, 1'b0);
      check("rst_ovr", ovr0, 1'b0);
      check("rst_cnt", cnt0, 8'h00);
      rst = 1'b0;
      tick();

      // basic decode and latency
      rdy_mode = 1;
      send_frame(8'hAD, 8'h3C, -1, -1, 1'b0, 1'b0, vb);
      check("lat_before", vb, 1'b0);
      check("t1_valid", p0_valid, 1'b1);
      check("t1_byte", p0_byte, 8'hA5);
      check("t1_cnt", cnt0, 8'd1);
      tick();

      // overrun while held
      rdy_mode = 0;
      send_frame(8'hAD, 8'h3C, -1, -1, 1'b0, 1'b0, vb);
      send_frame(8'h00, 8'h00, -1, -1, 1'b0, 1'b0, vb);
      check("ovr_byte", p0_byte, 8'hA5);
      check("ovr_set", ovr0, 1'b1);
      check("ovr_cnt", cnt0, 8'd2);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("ovr_clr", ovr0, 1'b0);

      // load and consume on the same edge
      send_frame(8'h00, 8'h00, -1, 1, 1'b0, 1'b0, vb);
      check("lc_valid", p0_valid, 1'b1);
      check("lc_byte", p0_byte, 8'h34);
      check("lc_cnt", cnt0, 8'd3);
      check("lc_ovr", ovr0, 1'b0);

      // drop and clear in the same cycle: drop wins
      send_frame(8'h11, 8'h22, -1, -1, 1'b1, 1'b0, vb);
      check("setwin_ovr", ovr0, 1'b1);
      check("setwin_byte", p0_byte, 8'h34);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;

      // glitch at bit 3: raw path keeps it, filter votes it out; the filter
      // history starts at zero so the leading 1 is voted down
      rdy_mode = 1;
      tick();
      send_frame(8'hFF, 8'h00, 3, -1, 1'b0, 1'b0, vb);
      check("glitch_raw", p0_byte, 8'hDB);
      check("glitch_flt", p1_byte, 8'h4B);

      // reset in the middle of a frame
      rdy_mode = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cipher_bit = 1'($urandom);
         b_bit = 1'($urandom);
         tick();
      end
      rst = 1'b1;
      model_reset();
      #1;
      check("mrst_byte", p0_byte, 8'h00);
      check("mrst_valid", p0_valid, 1'b0);
      check("mrst_busy", busy0, 1'b0);
      check("mrst_cnt", cnt0, 8'h00);
      check("mrst_valid_flt", p1_valid, 1'b0);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      rdy_mode = 1;
      send_frame(8'hAD, 8'h3C, -1, -1, 1'b0, 1'b0, vb);
      check("post_rst_byte", p0_byte, 8'hA5);
      check("post_rst_cnt", cnt0, 8'd1);

      // start pulses inside a frame are ignored
      send_frame(8'h5A, 8'hC3, -1, -1, 1'b0, 1'b1, vb);
      check("noisy_byte", p0_byte, 8'hAD);
      tick();
      check("noisy_idle", busy0, 1'b0);

      // 260 always-accepted frames: counter wraps
      cnt_before = m_cnt;
      for (int f = 0; f < 260; f++) begin
         key[7:0] = 8'($urandom);
         send_frame(8'($urandom), 8'($urandom), int'($urandom_range(0, 15)), -1, 1'b0,
                    1'($urandom_range(0, 1)), vb);
         repeat ($urandom_range(0, 2)) tick();
      end
      check("wrap_cnt", cnt0, 32'((int'(cnt_before) + 260) % 256));

      // random back-pressure with drops and clears
      rdy_mode = 2;
      for (int f = 0; f < 80; f++) begin
         key[7:0] = 8'($urandom);
         send_frame(8'($urandom), 8'($urandom), int'($urandom_range(0, 15)), -1,
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), vb);
         repeat ($urandom_range(0, 2)) tick();
      end

      rdy_mode = 1;
      repeat (3) tick();
      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
